wb_gpio_irq: RTL and testbench



---
 rtl/wb_gpio_pkg.sv | 17 +
 rtl/gpio_sync_edge.sv | 41 ++++
 rtl/wb_gpio_irq.sv | 135 +++++++++++++
 tb/tb_wb_gpio_irq.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_gpio_pkg.sv
// wb_gpio_pkg
// Shared definitions for the Wishbone GPIO controller: the word offsets of
// the eight registers in the map and the widest GPIO vector supported.
package wb_gpio_pkg;

    localparam int MAX_WIDTH = 32;

    localparam logic [2:0] REG_DATA_IN    = 3'd0;
    localparam logic [2:0] REG_DATA_OUT   = 3'd1;
    localparam logic [2:0] REG_DIR        = 3'd2;
    localparam logic [2:0] REG_OUT_SET    = 3'd3;
    localparam logic [2:0] REG_OUT_CLR    = 3'd4;
    localparam logic [2:0] REG_RISE_EN    = 3'd5;
    localparam logic [2:0] REG_FALL_EN    = 3'd6;
    localparam logic [2:0] REG_IRQ_STATUS = 3'd7;

endpackage

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge
// Brings asynchronous pin levels into the clock domain through a STAGES-deep
// flop chain and flags per-bit rising and falling edges against the previous
// synchronised value.
// Ports:
//   clock, reset   clock and asynchronous active-high reset
//   async_i        raw pin levels
//   sync_o         last synchroniser stage
//   rise_o/fall_o  one-cycle edge strobes, combinational from sync_o and prev
module gpio_sync_edge #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    logic [STAGES-1:0][WIDTH-1:0] chain_q;
    logic [WIDTH-1:0]             prev_q;

    // Stage 0 samples the pin; each later stage copies the one before it.
    // prev_q holds the synchronised value from the previous cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            chain_q <= '0;
            prev_q  <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], async_i};
            prev_q  <= chain_q[STAGES-1];
        end
    end

    assign sync_o = chain_q[STAGES-1];
    assign rise_o = sync_o & ~prev_q;
    assign fall_o = ~sync_o & prev_q;

endmodule

// File: rtl/wb_gpio_irq.sv
// wb_gpio_irq
// Wishbone classic GPIO controller with per-bit direction, atomic set/clear
// of outputs, synchronised inputs and sticky W1C edge interrupt status.
// Ports:
//   clock, reset          Wishbone clock, asynchronous active-high reset
//   wb_*                  Wishbone classic slave (3-bit word address)
//   gpio_i                asynchronous pin inputs
//   gpio_o, gpio_dir_o    output data and output enable (1 = drive)
//   irq_o                 registered OR of the interrupt status bits
module wb_gpio_irq
    import wb_gpio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       wb_adr_i,
    input  logic [31:0]      wb_dat_i,
    input  logic [3:0]       wb_sel_i,
    input  logic             wb_we_i,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    output logic [31:0]      wb_dat_o,
    output logic             wb_ack_o,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] gpio_dir_o,
    output logic             irq_o
);

    logic [WIDTH-1:0] dataOut_q, dataOut_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] riseEn_q, riseEn_d;
    logic [WIDTH-1:0] fallEn_q, fallEn_d;
    logic [WIDTH-1:0] status_q, status_d;
    logic [31:0]      dat_q;
    logic             ack_q;
    logic             irq_q;

    logic [WIDTH-1:0] syncIn, riseIn, fallIn;
    logic             access, wrEn;
    logic [31:0]      laneMask, writeBits, readData;
    logic [WIDTH-1:0] wrVal, wrMask, w1c;
    logic             unusedBits;

    gpio_sync_edge #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clock   (clock),
        .reset   (reset),
        .async_i (gpio_i),
        .sync_o  (syncIn),
        .rise_o  (riseIn),
        .fall_o  (fallIn)
    );

    // An access is accepted on the edge where ack rises; masking with ~ack_q
    // makes a held strobe produce one access per two cycles.
    assign access    = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wrEn      = access & wb_we_i;
    assign laneMask  = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
    assign writeBits = wb_dat_i & laneMask;
    assign wrVal     = writeBits[WIDTH-1:0];
    assign wrMask    = laneMask[WIDTH-1:0];
    // Bus bits above WIDTH are intentionally dropped.
    assign unusedBits = ^{writeBits, laneMask};

    // Next-state for the writable registers. Status applies the W1C first
    // and then ORs in new edges so a simultaneous set wins.
    always_comb begin
        dataOut_d = dataOut_q;
        dir_d     = dir_q;
        riseEn_d  = riseEn_q;
        fallEn_d  = fallEn_q;
        w1c       = '0;
        if (wrEn) begin
            case (wb_adr_i)
                REG_DATA_OUT:   dataOut_d = (dataOut_q & ~wrMask) | wrVal;
                REG_DIR:        dir_d     = (dir_q & ~wrMask) | wrVal;
                REG_OUT_SET:    dataOut_d = dataOut_q | wrVal;
                REG_OUT_CLR:    dataOut_d = dataOut_q & ~wrVal;
                REG_RISE_EN:    riseEn_d  = (riseEn_q & ~wrMask) | wrVal;
                REG_FALL_EN:    fallEn_d  = (fallEn_q & ~wrMask) | wrVal;
                REG_IRQ_STATUS: w1c       = wrVal;
                default:        ;
            endcase
        end
        status_d = (status_q & ~w1c) | (riseIn & riseEn_q) | (fallIn & fallEn_q);
    end

    // Read mux, zero-extended to the bus; OUT_SET/OUT_CLR read as zero.
    always_comb begin
        readData = '0;
        case (wb_adr_i)
            REG_DATA_IN:    readData[WIDTH-1:0] = syncIn;
            REG_DATA_OUT:   readData[WIDTH-1:0] = dataOut_q;
            REG_DIR:        readData[WIDTH-1:0] = dir_q;
            REG_RISE_EN:    readData[WIDTH-1:0] = riseEn_q;
            REG_FALL_EN:    readData[WIDTH-1:0] = fallEn_q;
            REG_IRQ_STATUS: readData[WIDTH-1:0] = status_q;
            default:        readData = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dataOut_q <= '0;
            dir_q     <= '0;
            riseEn_q  <= '0;
            fallEn_q  <= '0;
            status_q  <= '0;
            dat_q     <= '0;
            ack_q     <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            dataOut_q <= dataOut_d;
            dir_q     <= dir_d;
            riseEn_q  <= riseEn_d;
            fallEn_q  <= fallEn_d;
            status_q  <= status_d;
            dat_q     <= (access && !wb_we_i) ? readData : 32'h0;
            ack_q     <= access;
            irq_q     <= |status_q;
        end
    end

    assign wb_dat_o   = dat_q;
    assign wb_ack_o   = ack_q;
    assign gpio_o     = dataOut_q;
    assign gpio_dir_o = dir_q;
    assign irq_o      = irq_q;

endmodule

// File: tb/tb_wb_gpio_irq.sv
// tb_wb_gpio_irq
// Directed testbench for wb_gpio_irq at WIDTH = 16, SYNC_STAGES = 2.
// Inputs change on the falling clock edge and outputs are sampled there.
module tb_wb_gpio_irq;

    localparam int W = 16;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [2:0]   wb_adr_i = '0;
    logic [31:0]  wb_dat_i = '0;
    logic [3:0]   wb_sel_i = '0;
    logic         wb_we_i  = 1'b0;
    logic         wb_cyc_i = 1'b0;
    logic         wb_stb_i = 1'b0;
    logic [31:0]  wb_dat_o;
    logic         wb_ack_o;
    logic [W-1:0] gpio_i = '0;
    logic [W-1:0] gpio_o;
    logic [W-1:0] gpio_dir_o;
    logic         irq_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] rd;

    always #5 clock = ~clock;

    wb_gpio_irq #(
        .WIDTH       (W),
        .SYNC_STAGES (2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .wb_adr_i   (wb_adr_i),
        .wb_dat_i   (wb_dat_i),
        .wb_sel_i   (wb_sel_i),
        .wb_we_i    (wb_we_i),
        .wb_cyc_i   (wb_cyc_i),
        .wb_stb_i   (wb_stb_i),
        .wb_dat_o   (wb_dat_o),
        .wb_ack_o   (wb_ack_o),
        .gpio_i     (gpio_i),
        .gpio_o     (gpio_o),
        .gpio_dir_o (gpio_dir_o),
        .irq_o      (irq_o)
    );

    // One comparison: counts it and reports a failure with both values.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One Wishbone classic access; returns read data captured in the ack cycle.
    task automatic applyStimulus(input logic we, input logic [2:0] adr,
                                 input logic [31:0] dat, input logic [3:0] sel,
                                 output logic [31:0] rdata);
        bit gotAck = 0;
        @(negedge clock);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = dat;
        wb_sel_i = sel;
        rdata    = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (wb_ack_o) begin
                gotAck = 1;
                rdata  = wb_dat_o;
                break;
            end
        end
        if (!gotAck) checkOutput("ackTimeout", {31'b0, wb_ack_o}, 32'h1);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
    endtask

    initial begin
        // Reset held three cycles, then every register reads zero.
        repeat (3) @(negedge clock);
        reset = 1'b0;
        checkOutput("rstGpioO", {16'h0, gpio_o}, 32'h0);
        checkOutput("rstDirO", {16'h0, gpio_dir_o}, 32'h0);
        checkOutput("rstIrq", {31'h0, irq_o}, 32'h0);
        checkOutput("rstAck", {31'h0, wb_ack_o}, 32'h0);
        for (int a = 0; a < 8; a++) begin
            applyStimulus(1'b0, a[2:0], 32'h0, 4'hF, rd);
            checkOutput($sformatf("rstReg%0d", a), rd, 32'h0);
        end

        // Set/clear sequence.
        applyStimulus(1'b1, 3'd1, 32'h0000_000F, 4'hF, rd);
        checkOutput("dataOutWr", {16'h0, gpio_o}, 32'h0000_000F);
        applyStimulus(1'b1, 3'd3, 32'h0000_0030, 4'hF, rd);
        checkOutput("outSet", {16'h0, gpio_o}, 32'h0000_003F);
        applyStimulus(1'b1, 3'd4, 32'h0000_0003, 4'hF, rd);
        checkOutput("outClr", {16'h0, gpio_o}, 32'h0000_003C);
        applyStimulus(1'b0, 3'd1, 32'h0, 4'hF, rd);
        checkOutput("dataOutRd", rd, 32'h0000_003C);
        applyStimulus(1'b0, 3'd3, 32'h0, 4'hF, rd);
        checkOutput("outSetRd", rd, 32'h0);
        applyStimulus(1'b0, 3'd4, 32'h0, 4'hF, rd);
        checkOutput("outClrRd", rd, 32'h0);

        // Bits above WIDTH are dropped.
        applyStimulus(1'b1, 3'd1, 32'hFFFF_FFFF, 4'hF, rd);
        applyStimulus(1'b0, 3'd1, 32'h0, 4'hF, rd);
        checkOutput("widthTrunc", rd, 32'h0000_FFFF);
        applyStimulus(1'b1, 3'd1, 32'h0000_003C, 4'hF, rd);

        // Byte lanes on DIR.
        applyStimulus(1'b1, 3'd2, 32'h0000_0000, 4'hF, rd);
        applyStimulus(1'b1, 3'd2, 32'h0000_ABCD, 4'b0010, rd);
        applyStimulus(1'b0, 3'd2, 32'h0, 4'hF, rd);
        checkOutput("dirLane", rd, 32'h0000_AB00);
        checkOutput("dirOut", {16'h0, gpio_dir_o}, 32'h0000_AB00);
        applyStimulus(1'b1, 3'd2, 32'h0000_00CD, 4'b0001, rd);
        applyStimulus(1'b0, 3'd2, 32'h0, 4'hF, rd);
        checkOutput("dirLane0", rd, 32'h0000_ABCD);

        // Rising edge on bit 0: status at k+2, irq at k+3.
        applyStimulus(1'b1, 3'd5, 32'h0000_0001, 4'hF, rd);
        @(negedge clock);
        gpio_i[0] = 1'b1;
        repeat (3) @(negedge clock);
        checkOutput("irqNotYet", {31'h0, irq_o}, 32'h0);
        @(negedge clock);
        checkOutput("irqRise", {31'h0, irq_o}, 32'h1);
        applyStimulus(1'b0, 3'd7, 32'h0, 4'hF, rd);
        checkOutput("statusRise", rd, 32'h0000_0001);
        applyStimulus(1'b0, 3'd0, 32'h0, 4'hF, rd);
        checkOutput("dataIn", rd, 32'h0000_0001);
        applyStimulus(1'b1, 3'd7, 32'h0000_0001, 4'hF, rd);
        @(negedge clock);
        checkOutput("irqCleared", {31'h0, irq_o}, 32'h0);
        applyStimulus(1'b0, 3'd7, 32'h0, 4'hF, rd);
        checkOutput("statusW1c", rd, 32'h0);

        // Disabled edge on bit 7 leaves status clear.
        applyStimulus(1'b1, 3'd6, 32'h0000_0080, 4'hF, rd);
        @(negedge clock);
        gpio_i[7] = 1'b1;
        repeat (4) @(negedge clock);
        applyStimulus(1'b0, 3'd7, 32'h0, 4'hF, rd);
        checkOutput("riseDisabled", rd, 32'h0);

        // Falling edge of bit 7 coincides with a W1C of bit 7: set wins.
        @(negedge clock);
        gpio_i[7] = 1'b0;
        @(negedge clock);
        applyStimulus(1'b1, 3'd7, 32'h0000_0080, 4'hF, rd);
        applyStimulus(1'b0, 3'd7, 32'h0, 4'hF, rd);
        checkOutput("collision", rd, 32'h0000_0080);
        checkOutput("irqFall", {31'h0, irq_o}, 32'h1);
        applyStimulus(1'b1, 3'd7, 32'h0000_0080, 4'hF, rd);
        applyStimulus(1'b0, 3'd7, 32'h0, 4'hF, rd);
        checkOutput("fallCleared", rd, 32'h0);

        // Held strobe gives alternating acks.
        @(negedge clock);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b0;
        wb_adr_i = 3'd1;
        checkOutput("ackPat0", {31'h0, wb_ack_o}, 32'h0);
        @(negedge clock);
        checkOutput("ackPat1", {31'h0, wb_ack_o}, 32'h1);
        @(negedge clock);
        checkOutput("ackPat2", {31'h0, wb_ack_o}, 32'h0);
        @(negedge clock);
        checkOutput("ackPat3", {31'h0, wb_ack_o}, 32'h1);
        checkOutput("ackPatData", wb_dat_o, 32'h0000_003C);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;

        // Reset during an acknowledged write drops ack at once.
        @(negedge clock);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b1;
        wb_adr_i = 3'd1;
        wb_dat_i = 32'h0000_0055;
        wb_sel_i = 4'hF;
        @(posedge clock);
        #1 reset = 1'b1;
        #1;
        checkOutput("rstAckDrop", {31'h0, wb_ack_o}, 32'h0);
        checkOutput("rstMidGpio", {16'h0, gpio_o}, 32'h0);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        applyStimulus(1'b0, 3'd1, 32'h0, 4'hF, rd);
        checkOutput("rstMidData", rd, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
